alu_operand_stage: RTL and testbench

Decode/operand stage directly upstream of the ALU. Accepts one 32-bit instruction per cycle with register-file read data. Decodes the instruction into the 5-bit ALU function select. Resolves operand A/B with forwarding from the ALU output and the writeback port. Holds the result in a registered valid/ready output stage, with a one-entry skid buffer so upstream back-pressure is fully registered.

---
 rtl/alu_operand_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Decode/operand stage feeding the ALU. Decodes one instruction per
//            cycle into an ALU function select and two operands, resolving
//            register operands with forwarding from the ALU output and the
//            writeback port. The result is held in an output register (OR)
//            backed by a one-entry skid buffer (SK), so in_ready is a pure
//            register output.
// Ports    : clk, reset                  - clock, synchronous active-high reset
//            in_valid/in_ready/instr     - upstream instruction handshake
//            rs1_data, rs2_data          - register-file read data
//            wb_en, wb_reg, wb_data      - writeback forwarding source
//            alu_result                  - ALU output forwarding source
//            flush                       - discard all held instructions
//            out_valid/out_ready         - downstream handshake
//            alu_sel, alu_a, alu_b       - decoded ALU controls/operands
//            out_rd, out_wr_en, out_illegal - destination / status
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int DBITS    = 32,
    parameter int REG_BITS = 4,
    parameter int IMM_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic [DBITS-1:0]    rs1_data,
    input  logic [DBITS-1:0]    rs2_data,
    input  logic                wb_en,
    input  logic [REG_BITS-1:0] wb_reg,
    input  logic [DBITS-1:0]    wb_data,
    input  logic [DBITS-1:0]    alu_result,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          alu_sel,
    output logic [DBITS-1:0]    alu_a,
    output logic [DBITS-1:0]    alu_b,
    output logic [REG_BITS-1:0] out_rd,
    output logic                out_wr_en,
    output logic                out_illegal
);

    // Opcode classes
    localparam logic [3:0] c_OP_ALU_R = 4'h0;
    localparam logic [3:0] c_OP_ALU_I = 4'h8;
    localparam logic [3:0] c_OP_CMP_R = 4'h2;
    localparam logic [3:0] c_OP_CMP_I = 4'hA;

    // Occupancy states, encoded as {sk_valid, or_valid}
    localparam logic [1:0] c_ST_EMPTY = 2'b00;
    localparam logic [1:0] c_ST_ONE   = 2'b01;
    localparam logic [1:0] c_ST_FULL  = 2'b11;

    typedef struct packed {
        logic [4:0]          sel;
        logic [DBITS-1:0]    a;
        logic [DBITS-1:0]    b;
        logic [REG_BITS-1:0] rd;
        logic                wr_en;
        logic                illegal;
    } entry_t;

    entry_t r_or;
    entry_t r_sk;
    logic   r_or_valid;
    logic   r_sk_valid;
    logic   r_in_ready;

    entry_t              w_new;
    logic [3:0]          w_op;
    logic [3:0]          w_fn;
    logic [REG_BITS-1:0] w_rs1;
    logic [REG_BITS-1:0] w_rs2;
    logic [DBITS-1:0]    w_fwd1;
    logic [DBITS-1:0]    w_fwd2;
    logic [DBITS-1:0]    w_imm;
    logic                w_or_fwd_ok;

    logic [1:0] w_state;
    logic       w_accept;
    logic       w_drain;
    logic       w_or_load;
    logic       w_or_from_sk;
    logic       w_sk_load;
    logic       w_or_valid_nxt;
    logic       w_sk_valid_nxt;
    logic       w_in_ready_nxt;

    // ------------------------------------------------------------------------
    // Decode and operand resolution
    // ------------------------------------------------------------------------
    assign w_op  = instr[31:28];
    assign w_fn  = instr[27:24];
    assign w_rs1 = REG_BITS'(instr[19:16]);
    assign w_rs2 = REG_BITS'(instr[15:12]);
    assign w_imm = {{(DBITS-IMM_BITS){instr[IMM_BITS-1]}}, instr[IMM_BITS-1:0]};

    // The instruction in OR is the youngest producer; its result is on
    // alu_result this cycle, so it beats the older writeback.
    assign w_or_fwd_ok = r_or_valid && r_or.wr_en;

    always_comb begin
        w_fwd1 = rs1_data;
        if (w_or_fwd_ok && (r_or.rd == w_rs1)) begin
            w_fwd1 = alu_result;
        end else if (wb_en && (wb_reg == w_rs1)) begin
            w_fwd1 = wb_data;
        end
    end

    always_comb begin
        w_fwd2 = rs2_data;
        if (w_or_fwd_ok && (r_or.rd == w_rs2)) begin
            w_fwd2 = alu_result;
        end else if (wb_en && (wb_reg == w_rs2)) begin
            w_fwd2 = wb_data;
        end
    end

    always_comb begin
        w_new         = '0;
        w_new.rd      = REG_BITS'(instr[23:20]);
        case (w_op)
            c_OP_ALU_R: begin
                w_new.sel   = {1'b0, w_fn};
                w_new.a     = w_fwd1;
                w_new.b     = w_fwd2;
                w_new.wr_en = 1'b1;
            end
            c_OP_ALU_I: begin
                w_new.sel   = {1'b0, w_fn};
                w_new.a     = w_fwd1;
                w_new.b     = w_imm;
                w_new.wr_en = 1'b1;
            end
            c_OP_CMP_R: begin
                w_new.sel   = {1'b1, w_fn};
                w_new.a     = w_fwd1;
                w_new.b     = w_fwd2;
                w_new.wr_en = 1'b1;
            end
            c_OP_CMP_I: begin
                w_new.sel   = {1'b1, w_fn};
                w_new.a     = w_fwd1;
                w_new.b     = w_imm;
                w_new.wr_en = 1'b1;
            end
            default: begin
                // Unknown opcode still flows down the pipe, marked illegal
                w_new.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Occupancy control (OR + SK)
    // ------------------------------------------------------------------------
    assign w_state  = {r_sk_valid, r_or_valid};
    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = r_or_valid && out_ready;

    always_comb begin
        w_or_load      = 1'b0;
        w_or_from_sk   = 1'b0;
        w_sk_load      = 1'b0;
        w_or_valid_nxt = r_or_valid;
        w_sk_valid_nxt = r_sk_valid;
        case (w_state)
            c_ST_EMPTY: begin
                if (w_accept) begin
                    w_or_load      = 1'b1;
                    w_or_valid_nxt = 1'b1;
                end
            end
            c_ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_or_load = 1'b1;
                end else if (w_accept) begin
                    w_sk_load      = 1'b1;
                    w_sk_valid_nxt = 1'b1;
                end else if (w_drain) begin
                    w_or_valid_nxt = 1'b0;
                end
            end
            c_ST_FULL: begin
                // in_ready is low here, so only a drain can happen
                if (w_drain) begin
                    w_or_from_sk   = 1'b1;
                    w_sk_valid_nxt = 1'b0;
                end
            end
            default: begin
                // SK valid without OR valid is unreachable; recover to empty
                w_or_valid_nxt = 1'b0;
                w_sk_valid_nxt = 1'b0;
            end
        endcase
        if (flush) begin
            w_or_load      = 1'b0;
            w_or_from_sk   = 1'b0;
            w_sk_load      = 1'b0;
            w_or_valid_nxt = 1'b0;
            w_sk_valid_nxt = 1'b0;
        end
    end

    // Registered ready: derived from the next occupancy, never from out_ready
    // combinationally at the output.
    assign w_in_ready_nxt = !(w_or_valid_nxt && w_sk_valid_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
            r_in_ready <= 1'b1;
            r_or       <= '0;
            r_sk       <= '0;
        end else begin
            r_or_valid <= w_or_valid_nxt;
            r_sk_valid <= w_sk_valid_nxt;
            r_in_ready <= w_in_ready_nxt;
            if (w_or_load) begin
                r_or <= w_new;
            end else if (w_or_from_sk) begin
                r_or <= r_sk;
            end
            if (w_sk_load) begin
                r_sk <= w_new;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_or_valid;
    assign alu_sel     = r_or.sel;
    assign alu_a       = r_or.a;
    assign alu_b       = r_or.b;
    assign out_rd      = r_or.rd;
    assign out_wr_en   = r_or.wr_en;
    assign out_illegal = r_or.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Self-checking bench for alu_operand_stage. A two-deep FIFO model
//            with a decode table holds the expected instruction stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] alu_result;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  out_rd;
    logic        out_wr_en;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic        wr_en;
        logic        illegal;
    } ent_t;

    ent_t q[$];
    logic m_rdy;

    alu_operand_stage #(.DBITS(32), .REG_BITS(4), .IMM_BITS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .alu_result (alu_result),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .out_rd     (out_rd),
        .out_wr_en  (out_wr_en),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Operand source: youngest held producer, then writeback, then regfile
    function automatic logic [31:0] ref_operand(input logic [3:0] idx, input logic [31:0] rf);
        if (q.size() > 0 && q[0].wr_en && q[0].rd == idx) return alu_result;
        if (wb_en && wb_reg == idx) return wb_data;
        return rf;
    endfunction

    function automatic ent_t ref_decode(input logic [31:0] ins);
        ent_t        e;
        logic [3:0]  op;
        logic [31:0] sext;
        op   = ins[31:28];
        sext = {{16{ins[15]}}, ins[15:0]};
        e    = '0;
        e.rd = ins[23:20];
        if (op == 4'h0 || op == 4'h8 || op == 4'h2 || op == 4'hA) begin
            e.sel     = {(op == 4'h2 || op == 4'hA) ? 1'b1 : 1'b0, ins[27:24]};
            e.a       = ref_operand(ins[19:16], rs1_data);
            e.b       = (op == 4'h8 || op == 4'hA) ? sext : ref_operand(ins[15:12], rs2_data);
            e.wr_en   = 1'b1;
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    task automatic compare_outputs();
        check("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        if (q.size() > 0) begin
            check("alu_sel", {27'b0, alu_sel}, {27'b0, q[0].sel});
            check("alu_a", alu_a, q[0].a);
            check("alu_b", alu_b, q[0].b);
            check("out_rd", {28'b0, out_rd}, {28'b0, q[0].rd});
            check("out_wr_en", {31'b0, out_wr_en}, {31'b0, q[0].wr_en});
            check("out_illegal", {31'b0, out_illegal}, {31'b0, q[0].illegal});
        end
    endtask

    // Advance one clock: update the model from the current inputs, then
    // compare the DUT just after the edge.
    task automatic step();
        ent_t e;
        bit   acc;
        bit   drn;
        acc = in_valid && m_rdy;
        drn = (q.size() > 0) && out_ready;
        e   = ref_decode(instr);
        if (reset || flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        m_rdy = (q.size() < 2);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        flush      = 1'b0;
        wb_en      = 1'b0;
        wb_reg     = 4'h0;
        wb_data    = 32'h0;
        alu_result = 32'h0;
        out_ready  = 1'b1;
        instr      = 32'h0;
        rs1_data   = 32'h0;
        rs2_data   = 32'h0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'h1);
        check({tag, "_alu_sel"}, {27'b0, alu_sel}, 32'h0);
        check({tag, "_alu_a"}, alu_a, 32'h0);
        check({tag, "_alu_b"}, alu_b, 32'h0);
        check({tag, "_out_rd"}, {28'b0, out_rd}, 32'h0);
        check({tag, "_wr_en"}, {31'b0, out_wr_en}, 32'h0);
        check({tag, "_illegal"}, {31'b0, out_illegal}, 32'h0);
    endtask

    initial begin
        idle();
        m_rdy = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("reset");

        // ADD r3 = r1 + r2
        instr = 32'h00312000; rs1_data = 32'hA; rs2_data = 32'h6; in_valid = 1'b1;
        step();
        check("add_sel", {27'b0, alu_sel}, 32'h0);
        check("add_a", alu_a, 32'hA);
        check("add_b", alu_b, 32'h6);
        check("add_rd", {28'b0, out_rd}, 32'h3);
        check("add_wr", {31'b0, out_wr_en}, 32'h1);

        // CMP-I LT with imm 0xFFFF
        instr = 32'hA210FFFF; rs1_data = 32'h5;
        step();
        check("cmpi_sel", {27'b0, alu_sel}, 32'h12);
        check("cmpi_b", alu_b, 32'hFFFFFFFF);

        // Illegal opcode
        instr = 32'hF0000000;
        step();
        check("ill_flag", {31'b0, out_illegal}, 32'h1);
        check("ill_wr", {31'b0, out_wr_en}, 32'h0);
        check("ill_sel", {27'b0, alu_sel}, 32'h0);

        // Forwarding priority
        idle(); step();
        instr = 32'h00312000; in_valid = 1'b1; out_ready = 1'b0;
        step();
        instr = 32'h00533000; rs1_data = 32'h99; rs2_data = 32'h99;
        alu_result = 32'h10; wb_en = 1'b1; wb_reg = 4'h3; wb_data = 32'h20; out_ready = 1'b1;
        step();
        check("fwd_alu_a", alu_a, 32'h10);
        check("fwd_alu_b", alu_b, 32'h10);
        step();
        check("fwd_wb_a", alu_a, 32'h20);
        check("fwd_wb_b", alu_b, 32'h20);

        // Back-pressure: I0, I1, I2 with out_ready low
        idle(); step();
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h00112000; step();
        check("bp_rdy_after_i0", {31'b0, in_ready}, 32'h1);
        instr = 32'h00212000; step();
        check("bp_rdy_after_i1", {31'b0, in_ready}, 32'h0);
        instr = 32'h00412000; step();
        check("bp_held_rdy", {31'b0, in_ready}, 32'h0);
        check("bp_head_i0", {28'b0, out_rd}, 32'h1);
        out_ready = 1'b1; step();
        check("bp_head_i1", {28'b0, out_rd}, 32'h2);
        check("bp_rdy_rise", {31'b0, in_ready}, 32'h1);
        step();
        check("bp_head_i2", {28'b0, out_rd}, 32'h4);
        in_valid = 1'b0; step();
        check("bp_drained", {31'b0, out_valid}, 32'h0);

        // Flush while FULL with simultaneous input
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h00112000; step();
        instr = 32'h00212000; step();
        instr = 32'h00712000; flush = 1'b1; step();
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        check("flush_rdy", {31'b0, in_ready}, 32'h1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        check("flush_dropped", {31'b0, out_valid}, 32'h0);

        // Reset while FULL
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h00112000; step();
        instr = 32'h00212000; step();
        in_valid = 1'b0; reset = 1'b1; step();
        reset = 1'b0;
        check_reset_vals("midreset");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ops [6];
            ops = '{4'h0, 4'h8, 4'h2, 4'hA, 4'hF, 4'h5};
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            instr      = $urandom;
            instr[31:28] = ops[$urandom_range(0, 5)];
            instr[23:20] = 4'($urandom_range(0, 3));
            instr[19:16] = 4'($urandom_range(0, 3));
            instr[15:12] = 4'($urandom_range(0, 3));
            rs1_data   = $urandom;
            rs2_data   = $urandom;
            alu_result = $urandom;
            wb_en      = ($urandom_range(0, 1) != 0);
            wb_reg     = 4'($urandom_range(0, 3));
            wb_data    = $urandom;
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
